line_band_centroid: RTL

LINE_BAND_CENTROID -- requirements
Module: line_band_centroid

---
 rtl/line_band_centroid.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/line_band_centroid.sv
// line_band_centroid: per-band x-sum and count of thresholded line pixels over one camera frame, drained one band per handshake.
// Define LINE_CENTROID_DIV_EN to report floor(sum/count) through a restoring divider instead of the raw sum.
module line_band_centroid #(
  parameter int IMG_W = 320,
  parameter int IMG_H = 240,
  parameter int N_BANDS = 4,
  parameter int PIX_W = 8,
  parameter int BYTES_PER_PIX = 2,
  localparam int CW = $clog2(IMG_W * IMG_H / N_BANDS + 1),
  localparam int SW = $clog2(IMG_W) + CW,
  localparam int BW = N_BANDS > 1 ? $clog2(N_BANDS) : 1
) (
  input  logic             cam_pclk,
  input  logic             reset,
  input  logic             cam_vsync,
  input  logic             cam_href,
  input  logic [PIX_W-1:0] cam_data,
  input  logic [PIX_W-1:0] threshold,
  input  logic             invert,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [BW-1:0]    res_band,
  output logic [CW-1:0]    res_count,
  output logic [SW-1:0]    res_data,
  output logic             overflow
);
  localparam int XW = $clog2(IMG_W + 1);
  localparam int RW = $clog2(IMG_H + 1);
  typedef enum logic {WAIT, ACTIVE} cap_t;
  typedef enum logic [1:0] {IDLE, CALC, OUT} drn_t;
  cap_t cap_q, cap_d;
  drn_t drn_q, drn_d;
  logic vs_q, vs_p_q, hr_q, hr_p_q;
  logic [PIX_W-1:0] dat_q;
  logic [XW-1:0] x_q, x_d;
  logic [RW-1:0] row_q, row_d;
  logic ph_q, ph_d;
  logic [SW-1:0] sum_q [N_BANDS], sum_d [N_BANDS], rsum_q [N_BANDS], rsum_d [N_BANDS];
  logic [CW-1:0] cnt_q [N_BANDS], cnt_d [N_BANDS], rcnt_q [N_BANDS], rcnt_d [N_BANDS];
  logic [BW-1:0] band_q, band_d, pix_band;
  logic val_q, val_d, ovf_q, ovf_d, start, line_pix;
  logic [CW-1:0] rc_q, rc_d;
  logic [SW-1:0] rd_q, rd_d;
  assign pix_band = BW'(row_q / RW'(IMG_H / N_BANDS));
  assign line_pix = invert ? dat_q >= threshold : dat_q < threshold;
`ifdef LINE_CENTROID_DIV_EN
  localparam int DW = $clog2(SW + 1);
  logic [SW-1:0] quo_q, quo_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [DW-1:0] dc_q, dc_d;
  logic [CW:0] tr;
  logic ge;
  assign tr = {rem_q, quo_q[SW-1]};
  assign ge = tr >= {1'b0, rcnt_q[band_q]};
`endif
  always_comb begin
    cap_d = cap_q;
    drn_d = drn_q;
    x_d = x_q;
    row_d = row_q;
    ph_d = ph_q;
    sum_d = sum_q;
    cnt_d = cnt_q;
    rsum_d = rsum_q;
    rcnt_d = rcnt_q;
    band_d = band_q;
    val_d = val_q;
    ovf_d = ovf_q;
    rc_d = rc_q;
    rd_d = rd_q;
    start = 1'b0;
`ifdef LINE_CENTROID_DIV_EN
    quo_d = quo_q;
    rem_d = rem_q;
    dc_d = dc_q;
`endif
    if (cap_q == WAIT) begin
      if (vs_p_q && !vs_q) begin
        cap_d = ACTIVE;
        x_d = '0;
        row_d = '0;
        ph_d = 1'b0;
        sum_d = '{default: '0};
        cnt_d = '{default: '0};
      end
    end else if (vs_q && !vs_p_q) begin
      cap_d = WAIT;
      start = drn_q == IDLE;
      ovf_d = ovf_q | (drn_q != IDLE);
      rsum_d = drn_q == IDLE ? sum_q : rsum_q;
      rcnt_d = drn_q == IDLE ? cnt_q : rcnt_q;
    end else if (hr_p_q && !hr_q) begin
      x_d = '0;
      ph_d = 1'b0;
      row_d = row_q == RW'(IMG_H) ? row_q : row_q + 1'b1;
    end else if (hr_q) begin
      ph_d = BYTES_PER_PIX > 1 ? ~ph_q : 1'b0;
      if (!ph_q && line_pix && x_q < XW'(IMG_W) && row_q < RW'(IMG_H)) begin
        sum_d[pix_band] = sum_q[pix_band] + SW'(x_q);
        cnt_d[pix_band] = cnt_q[pix_band] + 1'b1;
      end
      if ((ph_q || BYTES_PER_PIX == 1) && x_q != XW'(IMG_W)) x_d = x_q + 1'b1;
    end
    if (drn_q == IDLE) begin
      if (start) begin
        drn_d = CALC;
        band_d = '0;
      end
    end else if (drn_q == CALC) begin
`ifdef LINE_CENTROID_DIV_EN
      quo_d = {quo_q[SW-2:0], ge};
      rem_d = ge ? tr[CW-1:0] - rcnt_q[band_q] : tr[CW-1:0];
      dc_d = dc_q + 1'b1;
      if (dc_q == DW'(SW - 1)) begin
        drn_d = OUT;
        val_d = 1'b1;
        rc_d = rcnt_q[band_q];
        rd_d = rcnt_q[band_q] == '0 ? '0 : quo_d;
      end
`else
      drn_d = OUT;
      val_d = 1'b1;
      rc_d = rcnt_q[band_q];
      rd_d = rsum_q[band_q];
`endif
    end else if (res_ready) begin
      val_d = 1'b0;
      drn_d = band_q == BW'(N_BANDS - 1) ? IDLE : CALC;
      band_d = band_q == BW'(N_BANDS - 1) ? '0 : band_q + 1'b1;
    end
`ifdef LINE_CENTROID_DIV_EN
    // Load the dividend on the way into CALC so the division takes exactly SW cycles.
    if (drn_d == CALC && drn_q != CALC) begin
      quo_d = rsum_d[band_d];
      rem_d = '0;
      dc_d = '0;
    end
`endif
  end
  always_ff @(posedge cam_pclk) begin
    if (reset) begin
      {vs_q, vs_p_q, hr_q, hr_p_q, ph_q, val_q, ovf_q} <= '0;
      dat_q <= '0;
      cap_q <= WAIT;
      drn_q <= IDLE;
      x_q <= '0;
      row_q <= '0;
      sum_q <= '{default: '0};
      cnt_q <= '{default: '0};
      rsum_q <= '{default: '0};
      rcnt_q <= '{default: '0};
      band_q <= '0;
      rc_q <= '0;
      rd_q <= '0;
`ifdef LINE_CENTROID_DIV_EN
      quo_q <= '0;
      rem_q <= '0;
      dc_q <= '0;
`endif
    end else begin
      {vs_q, vs_p_q, hr_q, hr_p_q} <= {cam_vsync, vs_q, cam_href, hr_q};
      dat_q <= cam_data;
      cap_q <= cap_d;
      drn_q <= drn_d;
      x_q <= x_d;
      row_q <= row_d;
      ph_q <= ph_d;
      sum_q <= sum_d;
      cnt_q <= cnt_d;
      rsum_q <= rsum_d;
      rcnt_q <= rcnt_d;
      band_q <= band_d;
      val_q <= val_d;
      ovf_q <= ovf_d;
      rc_q <= rc_d;
      rd_q <= rd_d;
`ifdef LINE_CENTROID_DIV_EN
      quo_q <= quo_d;
      rem_q <= rem_d;
      dc_q <= dc_d;
`endif
    end
  end
  assign res_valid = val_q;
  assign res_band = band_q;
  assign res_count = rc_q;
  assign res_data = rd_q;
  assign overflow = ovf_q;
endmodule
